// File: rtl/counter_increment_sequencer_pkg.sv
// Shared types and constants for the counter increment sequencer and its
// one's-complement increment unit.
package counter_increment_sequencer_pkg;

  localparam int WORD_W = 15;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    READ,
    WRITE
  } ctr_seq_state_t;

  localparam word_t CTR_BASE_DEFAULT = 15'o00024;

  localparam word_t POS_MAX  = 15'o37777;
  localparam word_t NEG_MAX  = 15'o40000;
  localparam word_t NEG_ZERO = 15'o77777;

endpackage

// File: rtl/counter_increment_sequencer_if.sv
// RAM port bundle: core-side requests in, muxed RAM port out, RAM read data back.
interface counter_increment_sequencer_if;
  import counter_increment_sequencer_pkg::*;

  word_t core_RAM_read_address;
  word_t core_RAM_write_address;
  word_t core_RAM_write_data;
  logic  core_RAM_write_en;

  word_t RAM_read_address;
  word_t RAM_write_address;
  word_t RAM_write_data;
  logic  RAM_write_en;
  word_t RAM_read_data;

  modport master (
    input  core_RAM_read_address,
    input  core_RAM_write_address,
    input  core_RAM_write_data,
    input  core_RAM_write_en,
    input  RAM_read_data,
    output RAM_read_address,
    output RAM_write_address,
    output RAM_write_data,
    output RAM_write_en
  );

  modport slave (
    output core_RAM_read_address,
    output core_RAM_write_address,
    output core_RAM_write_data,
    output core_RAM_write_en,
    output RAM_read_data,
    input  RAM_read_address,
    input  RAM_write_address,
    input  RAM_write_data,
    input  RAM_write_en
  );

endinterface

// File: rtl/counter_increment_sequencer_ones_comp_incr.sv
// 15-bit one's-complement +1/-1 with the counter wrap and overflow rules.
module ones_comp_incr
  import counter_increment_sequencer_pkg::*;
(
  input  word_t value,
  input  logic  up,
  output word_t result,
  output logic  ovf
);

  always_comb begin
    result = value;
    ovf    = 1'b0;
    if (up) begin
      if (value == POS_MAX) begin
        result = '0;
        ovf    = 1'b1;
      end else if (value == NEG_ZERO) begin
        result = WORD_W'(1);
      end else begin
        result = value + WORD_W'(1);
      end
    end else begin
      if (value == NEG_MAX) begin
        result = NEG_ZERO;
        ovf    = 1'b1;
      end else if (value == '0) begin
        result = NEG_ZERO - WORD_W'(1);
      end else begin
        result = value - WORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_increment_sequencer.sv
// Cycle-stealing PINC/MINC servicer: freezes the core, read-modify-writes the
// counter word through the shared RAM port, and flags overflow.
module counter_increment_sequencer
  import counter_increment_sequencer_pkg::*;
#(
  parameter int    NUM_CTR  = 8,
  parameter word_t CTR_BASE = CTR_BASE_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_CTR-1:0]   pinc_req,
  input  logic [NUM_CTR-1:0]   minc_req,
  counter_increment_sequencer_if.master bus,
  output logic                 core_hold,
  output logic [NUM_CTR-1:0]   ovf_pulse,
  output logic                 busy
);

  localparam int IDX_W = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;

  ctr_seq_state_t     state;
  logic [NUM_CTR-1:0] pend_p, pend_m;
  logic [IDX_W-1:0]   idx;
  logic               dir_up;

  logic [NUM_CTR-1:0] svc_p, svc_m, avail_p, avail_m, single, cancel;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_up;
  word_t              svc_addr, result;
  logic               ovf;

  // The word being written back is excluded so the next pick is a different service.
  always_comb begin
    svc_p = '0;
    svc_m = '0;
    if (state == WRITE) begin
      if (dir_up) svc_p[idx] = 1'b1;
      else        svc_m[idx] = 1'b1;
    end
    avail_p = pend_p & ~svc_p;
    avail_m = pend_m & ~svc_m;
    single  = avail_p ^ avail_m;
    cancel  = (state == IDLE) ? (pend_p & pend_m) : '0;

    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_up    = 1'b0;
    for (int i = NUM_CTR - 1; i >= 0; i--) begin
      if (single[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_up    = avail_p[i];
      end
    end
  end

  // A request arriving on the clearing cycle wins, so the bit survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_p <= '0;
      pend_m <= '0;
    end else begin
      pend_p <= (pend_p & ~svc_p & ~cancel) | pinc_req;
      pend_m <= (pend_m & ~svc_m & ~cancel) | minc_req;
    end
  end

  // Selection is latched when a service is committed; a late opposite request
  // for the same counter then simply stays pending for a later pass.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      core_hold <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      dir_up    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state     <= HOLD;
            idx       <= sel_idx;
            dir_up    <= sel_up;
            core_hold <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HOLD:  state <= READ;
        READ:  state <= WRITE;
        WRITE: begin
          if (sel_valid) begin
            state  <= READ;
            idx    <= sel_idx;
            dir_up <= sel_up;
          end else begin
            state     <= IDLE;
            core_hold <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign svc_addr = CTR_BASE + WORD_W'(idx);

  ones_comp_incr u_incr (
    .value  (bus.RAM_read_data),
    .up     (dir_up),
    .result (result),
    .ovf    (ovf)
  );

  always_comb begin
    bus.RAM_read_address  = bus.core_RAM_read_address;
    bus.RAM_write_address = bus.core_RAM_write_address;
    bus.RAM_write_data    = bus.core_RAM_write_data;
    bus.RAM_write_en      = bus.core_RAM_write_en;
    ovf_pulse             = '0;
    case (state)
      READ: begin
        bus.RAM_read_address = svc_addr;
        bus.RAM_write_en     = 1'b0;
      end
      WRITE: begin
        bus.RAM_write_address = svc_addr;
        bus.RAM_write_data    = result;
        bus.RAM_write_en      = 1'b1;
        ovf_pulse[idx]        = ovf;
      end
      default: ;
    endcase
  end

endmodule
